// File: rtl/stepgen_pkg.sv
// Shared definitions for the step-time generator: register map,
// move-entry layout, FSM states and a small helper.
package kstep_pkg;

  localparam logic [3:0] ADDR_INTERVAL = 4'd0;
  localparam logic [3:0] ADDR_PUSH     = 4'd1;
  localparam logic [3:0] ADDR_CLEAR    = 4'd2;

  typedef struct packed {
    logic [31:0]        interval;
    logic [15:0]        count;
    logic signed [15:0] add;
  } entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // A period of zero would never expire; the shortest legal period is one cycle.
  function automatic logic [31:0] nonzero(input logic [31:0] v);
    return (v == 32'd0) ? 32'd1 : v;
  endfunction

endpackage

// File: rtl/stepgen_if.sv
// Wishbone register-port bundle for the step-time generator.
interface stepgen_if;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic [3:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;

  modport master (
    output wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_stb_i, wb_cyc_i, wb_we_i, wb_adr_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/stepgen_fifo.sv
// Small synchronous FIFO of move entries. The head is read combinationally
// from the register file so the sequencer can inspect and pop it in the same
// cycle. A push into a full FIFO is accepted when a pop happens alongside it.
module stepgen_fifo
  import kstep_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 push_data,
  output entry_t                 head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [AW:0]     count_reg;
  logic            push_ok;
  logic            pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign level   = count_reg;
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem[rd_ptr_reg];

  // Storage write; no reset on the array so it maps onto plain memory.
  always_ff @(posedge clk) begin
    if (!rst && !flush && push_ok) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush empties the FIFO like reset.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_reg + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

endmodule

// File: rtl/stepgen.sv
// Step-time generator: wishbone-fed queue of moves, each producing a train of
// single-cycle step pulses whose spacing starts at `interval` and changes by
// `add` after every step. Back-to-back moves chain without an idle cycle.
module stepgen
  import kstep_pkg::*;
#(
  parameter int QUEUE_DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  output logic      step_pulse,
  stepgen_if.slave  wb
);

  localparam int LW = $clog2(QUEUE_DEPTH) + 1;

  logic          wr_cmd;
  logic          stage_req;
  logic          push_req;
  logic          clear_req;
  entry_t        push_entry;
  entry_t        head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          fifo_pop;
  logic          head_load;
  logic          last_step;
  logic          push_drop;
  logic [31:0]   step_sum;
  logic [31:0]   load_iv;
  logic [2:0]    level_field;

  state_t        state_reg;
  logic [31:0]   interval_reg;
  logic [31:0]   timer_reg;
  logic [31:0]   cur_reg;
  logic [15:0]   rem_reg;
  logic [15:0]   add_reg;
  logic          overflow_reg;

  assign wr_cmd    = wb.wb_cyc_i && wb.wb_stb_i && wb.wb_we_i;
  assign stage_req = wr_cmd && (wb.wb_adr_i == ADDR_INTERVAL);
  assign push_req  = wr_cmd && (wb.wb_adr_i == ADDR_PUSH);
  assign clear_req = wr_cmd && (wb.wb_adr_i == ADDR_CLEAR);

  assign push_entry = '{interval: interval_reg,
                        count:    wb.wb_dat_i[15:0],
                        add:      wb.wb_dat_i[31:16]};

  // The final step of a move may hand over straight to a non-empty next move;
  // a zero-count head is left for IDLE to discard.
  assign last_step = (state_reg == ST_RUN) && (timer_reg == 32'd1) && (rem_reg == 16'd1);
  assign fifo_pop  = !clear_req && !fifo_empty &&
                     ((state_reg == ST_IDLE) || (last_step && (head.count != 16'd0)));
  assign head_load = fifo_pop && (head.count != 16'd0);
  assign push_drop = push_req && fifo_full && !fifo_pop;

  assign step_sum = cur_reg + {{16{add_reg[15]}}, add_reg};
  assign load_iv  = nonzero(head.interval);

  generate
    if (LW >= 3) begin : g_level_wide
      assign level_field = fifo_level[2:0];
    end else begin : g_level_narrow
      assign level_field = {{(3 - LW){1'b0}}, fifo_level};
    end
  endgenerate

  assign wb.wb_dat_o = {16'b0, overflow_reg, (state_reg == ST_RUN), 11'b0, level_field};
  assign wb.wb_ack_o = 1'b1;

  stepgen_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .pop      (fifo_pop),
    .flush    (clear_req),
    .push_data(push_entry),
    .head     (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  // Staging register for the interval of the next pushed move.
  always_ff @(posedge clk) begin
    if (rst) begin
      interval_reg <= '0;
    end else if (stage_req) begin
      interval_reg <= wb.wb_dat_i;
    end
  end

  // Move sequencer: loads moves, counts down each step period, emits pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      step_pulse   <= 1'b0;
      timer_reg    <= '0;
      cur_reg      <= '0;
      rem_reg      <= '0;
      add_reg      <= '0;
      overflow_reg <= 1'b0;
    end else if (clear_req) begin
      state_reg    <= ST_IDLE;
      step_pulse   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      step_pulse <= 1'b0;
      if (push_drop) overflow_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (head_load) begin
            timer_reg <= load_iv;
            cur_reg   <= load_iv;
            rem_reg   <= head.count;
            add_reg   <= head.add;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (timer_reg == 32'd1) begin
            step_pulse <= 1'b1;
            rem_reg    <= rem_reg - 16'd1;
            if (rem_reg != 16'd1) begin
              cur_reg   <= step_sum;
              timer_reg <= nonzero(step_sum);
            end else if (head_load) begin
              timer_reg <= load_iv;
              cur_reg   <= load_iv;
              rem_reg   <= head.count;
              add_reg   <= head.add;
            end else begin
              state_reg <= ST_IDLE;
            end
          end else begin
            timer_reg <= timer_reg - 32'd1;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stepgen.sv
// Self-checking bench for stepgen: directed scenarios plus random wishbone
// traffic, compared every cycle against a schedule-based reference model.
module tb_stepgen;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic step_pulse;

  stepgen_if bus ();

  stepgen #(
    .QUEUE_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .step_pulse(step_pulse),
    .wb        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint cyc_n = 0;

  typedef struct {
    int unsigned interval;
    int unsigned count;
    int          add;
  } mv_t;

  // Reference model: queued moves, absolute cycle numbers of pending pulses.
  mv_t         mq[$];
  longint      sched[$];
  longint      pulses[$];
  bit          m_run;
  bit          m_ovf;
  bit          m_pulse;
  longint      m_last;
  int unsigned m_stage;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0h expected %0h", tag, cyc_n, got, exp);
    end
  endtask

  // Expand a whole move into its absolute pulse times when it is loaded.
  function automatic void model_load(input mv_t m);
    int unsigned cur;
    int unsigned gap;
    longint t;
    cur = (m.interval == 0) ? 1 : m.interval;
    t = cyc_n + longint'(cur);
    sched.push_back(t);
    for (int unsigned k = 1; k < m.count; k++) begin
      cur = cur + unsigned'(m.add);
      gap = (cur == 0) ? 1 : cur;
      t = t + longint'(gap);
      sched.push_back(t);
    end
    m_last = t;
    m_run  = 1'b1;
  endfunction

  function automatic void model_edge();
    bit  wr;
    mv_t mv;
    wr = bus.wb_cyc_i && bus.wb_stb_i && bus.wb_we_i;
    if (rst) begin
      mq.delete(); sched.delete();
      m_run = 0; m_ovf = 0; m_pulse = 0; m_stage = 0;
      return;
    end
    if (wr && bus.wb_adr_i == 4'd2) begin
      mq.delete(); sched.delete();
      m_run = 0; m_ovf = 0; m_pulse = 0;
      return;
    end
    m_pulse = (sched.size() > 0) && (sched[0] == cyc_n);
    if (m_pulse) void'(sched.pop_front());
    if (!m_run) begin
      if (mq.size() > 0) begin
        mv = mq.pop_front();
        if (mv.count != 0) model_load(mv);
      end
    end else if (cyc_n == m_last) begin
      if (mq.size() > 0 && mq[0].count != 0) begin
        mv = mq.pop_front();
        model_load(mv);
      end else begin
        m_run = 0;
      end
    end
    if (wr && bus.wb_adr_i == 4'd1) begin
      if (mq.size() < DEPTH) begin
        mv.interval = m_stage;
        mv.count    = bus.wb_dat_i[15:0];
        mv.add      = $signed(bus.wb_dat_i[31:16]);
        mq.push_back(mv);
      end else begin
        m_ovf = 1;
      end
    end
    if (wr && bus.wb_adr_i == 4'd0) m_stage = bus.wb_dat_i;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] e;
    e = '0;
    e[15]  = m_ovf;
    e[14]  = m_run;
    e[2:0] = 3'(mq.size());
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    cyc_n++;
    model_edge();
    #1;
    if (step_pulse === 1'b1) pulses.push_back(cyc_n);
    check("pulse", {31'b0, step_pulse}, {31'b0, m_pulse});
    check("status", bus.wb_dat_o, exp_status());
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic idle_bus();
    bus.wb_cyc_i = 0; bus.wb_stb_i = 0; bus.wb_we_i = 0;
    bus.wb_adr_i = '0; bus.wb_dat_i = '0;
  endtask

  task automatic wb_write(input logic [3:0] a, input logic [31:0] d);
    bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 1;
    bus.wb_adr_i = a; bus.wb_dat_i = d;
    $display("WB WR adr=%0d dat=%08h cycle %0d", a, d, cyc_n + 1);
    step();
    idle_bus();
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!m_run && mq.size() == 0) begin
        done = 1;
        break;
      end
      step();
    end
    check("drain_timeout", {31'b0, done}, 32'd1);
    run(2);
    pulses.delete();
  endtask

  // Compare logged pulse offsets from `base` against up to three expected values.
  task automatic expect_pulses(input string tag, input longint base, input int n,
                               input int o0, input int o1, input int o2);
    longint got;
    int     exp;
    check({tag, "_count"}, 32'(pulses.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < pulses.size()) ? pulses[i] - base : -1;
      exp = (i == 0) ? o0 : (i == 1) ? o1 : o2;
      check($sformatf("%s_%0d", tag, i), 32'(got), 32'(exp));
    end
  endtask

  initial begin
    longint L;
    int r;
    int unsigned cnt;
    int add;
    idle_bus();
    rst = 1;
    run(2);
    rst = 0;
    check("reset_status", bus.wb_dat_o, 32'd0);
    check("reset_pulse", {31'b0, step_pulse}, 32'd0);
    check("ack", {31'b0, bus.wb_ack_o}, 32'd1);
    pulses.delete();

    // Constant spacing.
    wb_write(4'd0, 32'd10);
    wb_write(4'd1, {16'd0, 16'd3});
    L = cyc_n + 1;
    run(35);
    expect_pulses("t1", L, 3, 10, 20, 30);
    check("t1_active", {31'b0, bus.wb_dat_o[14]}, 32'd0);
    drain();

    // Decreasing spacing: gaps 10, 8, 6.
    wb_write(4'd0, 32'd10);
    wb_write(4'd1, {16'hFFFE, 16'd3});
    L = cyc_n + 1;
    run(30);
    expect_pulses("t2", L, 3, 10, 18, 24);
    drain();

    // Two chained moves, no gap between them.
    wb_write(4'd0, 32'd5);
    wb_write(4'd1, {16'd0, 16'd2});
    L = cyc_n + 1;
    wb_write(4'd0, 32'd7);
    wb_write(4'd1, {16'd0, 16'd1});
    run(20);
    expect_pulses("t3", L, 3, 5, 10, 17);
    drain();

    // Period reaching zero is stretched to one cycle.
    wb_write(4'd0, 32'd2);
    wb_write(4'd1, {16'hFFFE, 16'd2});
    L = cyc_n + 1;
    run(6);
    expect_pulses("tz", L, 2, 2, 3, 0);
    drain();

    // Staged interval of zero behaves as one.
    wb_write(4'd0, 32'd0);
    wb_write(4'd1, {16'd0, 16'd2});
    L = cyc_n + 1;
    run(5);
    expect_pulses("ti0", L, 2, 1, 2, 0);
    drain();

    // Overflow while a long move blocks the queue, then clear.
    wb_write(4'd0, 32'd1000);
    wb_write(4'd1, {16'd0, 16'd1});
    run(2);
    wb_write(4'd0, 32'd3);
    for (int i = 0; i < 5; i++) wb_write(4'd1, {16'd0, 16'd1});
    check("t4_level", {29'b0, bus.wb_dat_o[2:0]}, 32'd4);
    check("t4_ovf", {31'b0, bus.wb_dat_o[15]}, 32'd1);
    wb_write(4'd2, 32'd0);
    check("t4_clr_level", {29'b0, bus.wb_dat_o[2:0]}, 32'd0);
    check("t4_clr_ovf", {31'b0, bus.wb_dat_o[15]}, 32'd0);
    check("t4_clr_active", {31'b0, bus.wb_dat_o[14]}, 32'd0);
    drain();

    // Clear on the cycle the timer expires suppresses the pulse.
    wb_write(4'd0, 32'd4);
    wb_write(4'd1, {16'd0, 16'd1});
    run(4);
    wb_write(4'd2, 32'd0);
    check("t5_pulse", {31'b0, step_pulse}, 32'd0);
    check("t5_active", {31'b0, bus.wb_dat_o[14]}, 32'd0);
    run(5);
    check("t5_none", 32'(pulses.size()), 32'd0);
    drain();

    // Reset mid-move, then a short move and a zero-count move.
    wb_write(4'd0, 32'd50);
    wb_write(4'd1, {16'd0, 16'd2});
    run(10);
    rst = 1;
    $display("RST cycle %0d", cyc_n + 1);
    step();
    rst = 0;
    check("t6_rst_status", bus.wb_dat_o, 32'd0);
    pulses.delete();
    wb_write(4'd0, 32'd3);
    wb_write(4'd1, {16'd0, 16'd1});
    L = cyc_n + 1;
    run(6);
    expect_pulses("t6", L, 1, 3, 0, 0);
    pulses.delete();
    wb_write(4'd1, {16'd0, 16'd0});
    run(6);
    check("t6_zero", 32'(pulses.size()), 32'd0);
    drain();

    // Random traffic against the model.
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) begin
        rst = 1;
        $display("RST cycle %0d", cyc_n + 1);
        step();
        rst = 0;
      end else if (r < 5) begin
        wb_write(4'd2, $urandom);
      end else if (r < 20) begin
        wb_write(4'd0, ($urandom_range(0, 9) == 0) ? 32'd0 : 32'($urandom_range(1, 24)));
      end else if (r < 45) begin
        cnt = $urandom_range(0, 4);
        if (m_stage >= 10) add = int'($urandom_range(0, 4)) - 2;
        else if (m_stage == 0) add = 0;
        else add = int'($urandom_range(0, 3));
        wb_write(4'd1, {16'(add), 16'(cnt)});
      end else if (r < 52) begin
        bus.wb_cyc_i = 1; bus.wb_stb_i = 1; bus.wb_we_i = 0;
        bus.wb_adr_i = 4'($urandom_range(0, 15)); bus.wb_dat_i = $urandom;
        $display("WB RD adr=%0d cycle %0d", bus.wb_adr_i, cyc_n + 1);
        step();
        idle_bus();
      end else if (r < 57) begin
        bus.wb_we_i = 1; bus.wb_adr_i = 4'($urandom_range(0, 2));
        bus.wb_dat_i = {16'd0, 16'd1};
        if ($urandom_range(0, 1) == 1) begin
          bus.wb_cyc_i = 1; bus.wb_stb_i = 0;
        end else begin
          bus.wb_cyc_i = 0; bus.wb_stb_i = 1;
        end
        step();
        idle_bus();
      end else if (r < 60) begin
        wb_write(4'($urandom_range(3, 15)), $urandom);
      end else begin
        step();
      end
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
